// File: rtl/ctrl_pipe_stage.sv
// Pipeline stage register for control bundles: valid/ready handshake with a 2-entry skid, flush to bubbles.
// Optional statistics (stall_cnt, drop_cnt) are compiled in when CTRL_PIPE_STATS_EN is defined.
module ctrl_pipe_stage #(
    parameter int                WIDTH     = 18,
    parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_ctrl,
`ifdef CTRL_PIPE_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake rule: a word moves on a rising edge only when valid and ready are both 1;
    // valid never depends on ready, and in_ready/out_valid come straight from flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_main;
    logic [WIDTH-1:0]  r_skid;
    logic [WIDTH-1:0]  w_main_nxt;
    logic [WIDTH-1:0]  w_skid_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_in_hs;
    logic              w_out_hs;

    assign w_in_hs  = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_in_hs) begin
                    w_state_nxt = S_BUSY;
                    w_main_nxt  = in_ctrl;
                end
            end
            S_BUSY: begin
                case ({w_in_hs, w_out_hs})
                    2'b11: w_main_nxt = in_ctrl;
                    2'b10: begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = in_ctrl;
                    end
                    2'b01: w_state_nxt = S_EMPTY;
                    default: ;
                endcase
            end
            S_FULL: begin
                // in_ready is 0 here, so only the drain path exists.
                if (w_out_hs) begin
                    w_state_nxt = S_BUSY;
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = NOP_VALUE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main      <= NOP_VALUE;
            r_skid      <= NOP_VALUE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != S_FULL);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_valid ? r_main : NOP_VALUE;
    assign dbg_state = r_state;

`ifdef CTRL_PIPE_STATS_EN
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [1:0]        w_drop_inc;
    logic [CNT_W:0]    w_drop_sum;

    // Main is lost unless it left this cycle; skid is lost whenever valid; an accepted input is lost too.
    assign w_drop_inc = flush ? ({1'b0, r_out_valid & ~out_ready}
                               + {1'b0, (r_state == S_FULL)}
                               + {1'b0, w_in_hs}) : 2'd0;
    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign drop_cnt  = r_drop_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
